// File: rtl/irig_time_keeper_if.sv
// Bus between the IRIG decoder side and the time keeper:
// decoded fields, pps/trigger strobes, running time and capture.
interface irig_time_keeper_if;
  logic [31:0] cycles_per_sec;
  logic [7:0]  holdover_max;
  logic        leap;
  logic [5:0]  sec;
  logic [5:0]  min;
  logic [4:0]  hr;
  logic [8:0]  day;
  logic        bcd_valid;
  logic        pps;
  logic        trigger;
  logic [5:0]  t_sec;
  logic [5:0]  t_min;
  logic [4:0]  t_hr;
  logic [8:0]  t_day;
  logic [31:0] t_subsec;
  logic        locked;
  logic        holdover;
  logic        mismatch;
  logic        bad_frame;
  logic [5:0]  cap_sec;
  logic [5:0]  cap_min;
  logic [4:0]  cap_hr;
  logic [8:0]  cap_day;
  logic [31:0] cap_subsec;
  logic        cap_locked;
  logic        cap_valid;

  modport master (
    output cycles_per_sec, holdover_max, leap,
    output sec, min, hr, day,
    output bcd_valid, pps, trigger,
    input  t_sec, t_min, t_hr, t_day, t_subsec,
    input  locked, holdover, mismatch, bad_frame,
    input  cap_sec, cap_min, cap_hr, cap_day,
    input  cap_subsec, cap_locked, cap_valid
  );

  modport slave (
    input  cycles_per_sec, holdover_max, leap,
    input  sec, min, hr, day,
    input  bcd_valid, pps, trigger,
    output t_sec, t_min, t_hr, t_day, t_subsec,
    output locked, holdover, mismatch, bad_frame,
    output cap_sec, cap_min, cap_hr, cap_day,
    output cap_subsec, cap_locked, cap_valid
  );
endinterface

// File: rtl/irig_time_keeper.sv
// Time-of-day keeper disciplined to the decoder pps,
// with holdover flywheel and trigger timestamp capture.
module irig_time_keeper (
  input  logic clk,
  input  logic rst,
  irig_time_keeper_if.slave bus
);

  typedef struct packed {
    logic [8:0] day;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
  } tod_t;

  typedef enum logic [1:0] {
    UNLOCKED,
    WAIT_PPS,
    LOCKED,
    HOLDOVER
  } state_e;

  function automatic tod_t tod_inc(
    input tod_t t,
    input logic lp
  );
    tod_t r;
    r = t;
    if (t.sec >= 6'd59) begin
      r.sec = 6'd0;
      if (t.min >= 6'd59) begin
        r.min = 6'd0;
        if (t.hr >= 5'd23) begin
          r.hr = 5'd0;
          if (t.day >= (lp ? 9'd366 : 9'd365))
            r.day = 9'd1;
          else
            r.day = t.day + 9'd1;
        end else begin
          r.hr = t.hr + 5'd1;
        end
      end else begin
        r.min = t.min + 6'd1;
      end
    end else begin
      r.sec = t.sec + 6'd1;
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  tod_t        tod_q, tod_d;
  tod_t        pend_q, pend_d;
  tod_t        cap_q, cap_d;
  tod_t        frame;
  logic [31:0] sub_q, sub_d;
  logic [31:0] csub_q, csub_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic        reload_q, reload_d;
  logic        mism_q, mism_d;
  logic        bad_q, bad_d;
  logic        cl_q, cl_d;
  logic        cv_q, cv_d;

  logic [31:0] half;
  logic [31:0] last;
  logic [8:0]  day_max;
  logic        frame_ok;
  logic        is_lock;
  logic        late;
  logic        ho_exp;

  assign frame   = '{day: bus.day, hr: bus.hr,
                     min: bus.min, sec: bus.sec};
  assign day_max = bus.leap ? 9'd366 : 9'd365;
  assign half    = bus.cycles_per_sec >> 1;
  assign last    = bus.cycles_per_sec - 32'd1;
  assign is_lock = (state_q == LOCKED) ||
                   (state_q == HOLDOVER);
  assign late    = (state_q == HOLDOVER) &&
                   (sub_q < half);

  always_comb begin
    frame_ok = 1'b0;
    if (bus.bcd_valid) begin
      frame_ok = (bus.sec <= 6'd59) &&
                 (bus.min <= 6'd59) &&
                 (bus.hr <= 5'd23) &&
                 (bus.day != 9'd0) &&
                 (bus.day <= day_max);
    end
  end

  // self-timed increment count reaching a nonzero limit drops lock
  assign ho_exp = (bus.holdover_max != 8'd0) &&
                  (hcnt_q + 8'd1 == bus.holdover_max);

  always_comb begin
    state_d  = state_q;
    tod_d    = tod_q;
    sub_d    = sub_q;
    pend_d   = pend_q;
    reload_d = reload_q;
    hcnt_d   = hcnt_q;
    mism_d   = 1'b0;
    bad_d    = bus.bcd_valid & ~frame_ok;
    unique case (state_q)
      UNLOCKED: begin
        if (frame_ok) begin
          pend_d  = frame;
          state_d = WAIT_PPS;
        end
      end
      WAIT_PPS: begin
        if (bus.pps) begin
          tod_d   = tod_inc(pend_q, bus.leap);
          sub_d   = '0;
          state_d = LOCKED;
        end
        if (frame_ok)
          pend_d = frame;
      end
      LOCKED, HOLDOVER: begin
        if (bus.pps) begin
          sub_d   = '0;
          hcnt_d  = '0;
          state_d = LOCKED;
          if (!late) begin
            tod_d    = tod_inc(reload_q ? pend_q : tod_q,
                               bus.leap);
            reload_d = 1'b0;
          end
        end else if (sub_q == last) begin
          tod_d   = tod_inc(tod_q, bus.leap);
          sub_d   = '0;
          hcnt_d  = hcnt_q + 8'd1;
          state_d = HOLDOVER;
          if (ho_exp) begin
            hcnt_d  = '0;
            state_d = UNLOCKED;
          end
        end else begin
          sub_d = sub_q + 32'd1;
        end
        // frame is judged against the time after this cycle's update
        if (frame_ok && (frame != tod_d)) begin
          mism_d   = 1'b1;
          pend_d   = frame;
          reload_d = 1'b1;
        end
        if (state_d == UNLOCKED)
          reload_d = 1'b0;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_comb begin
    cap_d  = cap_q;
    csub_d = csub_q;
    cl_d   = cl_q;
    cv_d   = bus.trigger;
    if (bus.trigger) begin
      cap_d  = tod_q;
      csub_d = sub_q;
      cl_d   = is_lock;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= UNLOCKED;
      tod_q    <= '0;
      sub_q    <= '0;
      pend_q   <= '0;
      reload_q <= 1'b0;
      hcnt_q   <= '0;
      mism_q   <= 1'b0;
      bad_q    <= 1'b0;
      cap_q    <= '0;
      csub_q   <= '0;
      cl_q     <= 1'b0;
      cv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tod_q    <= tod_d;
      sub_q    <= sub_d;
      pend_q   <= pend_d;
      reload_q <= reload_d;
      hcnt_q   <= hcnt_d;
      mism_q   <= mism_d;
      bad_q    <= bad_d;
      cap_q    <= cap_d;
      csub_q   <= csub_d;
      cl_q     <= cl_d;
      cv_q     <= cv_d;
    end
  end

  assign bus.t_sec      = tod_q.sec;
  assign bus.t_min      = tod_q.min;
  assign bus.t_hr       = tod_q.hr;
  assign bus.t_day      = tod_q.day;
  assign bus.t_subsec   = sub_q;
  assign bus.locked     = is_lock;
  assign bus.holdover   = (state_q == HOLDOVER);
  assign bus.mismatch   = mism_q;
  assign bus.bad_frame  = bad_q;
  assign bus.cap_sec    = cap_q.sec;
  assign bus.cap_min    = cap_q.min;
  assign bus.cap_hr     = cap_q.hr;
  assign bus.cap_day    = cap_q.day;
  assign bus.cap_subsec = csub_q;
  assign bus.cap_locked = cl_q;
  assign bus.cap_valid  = cv_q;

endmodule

// File: tb/tb_irig_time_keeper.sv
// Scoreboard bench for irig_time_keeper: a seconds-of-year
// reference model predicts every cycle, a monitor compares.
module tb_irig_time_keeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  irig_time_keeper_if bus();

  irig_time_keeper dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] t;
    logic [31:0] sub;
    logic [1:0]  st;
    logic [2:0]  pl;
    logic [25:0] ct;
    logic [31:0] cs;
    logic        cl;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // model: time as seconds since day-1 midnight, day 0 => negative
  localparam int M_UNL = 0;
  localparam int M_WAIT = 1;
  localparam int M_LCK = 2;
  localparam int M_HOLD = 3;
  int          m_mode;
  int          m_t, m_pend, m_ct;
  int unsigned m_sub, m_cs;
  int          m_hc;
  bit          m_reload, m_cl;
  bit          m_mism, m_bad, m_cv;

  function automatic int to_s(int d, int h, int mi, int s);
    return ((d - 1) * 24 + h) * 3600 + mi * 60 + s;
  endfunction

  function automatic logic [25:0] to_f(int x);
    int d, r;
    if (x < 0) return 26'd0;
    d = x / 86400 + 1;
    r = x % 86400;
    return {9'(d), 5'(r / 3600), 6'((r / 60) % 60), 6'(r % 60)};
  endfunction

  function automatic int nxt(int x);
    int yl;
    yl = (bus.leap ? 366 : 365) * 86400;
    return (x + 1) % yl;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.t   = to_f(m_t);
    e.sub = m_sub;
    e.st  = {m_mode >= M_LCK, m_mode == M_HOLD};
    e.pl  = {m_mism, m_bad, m_cv};
    e.ct  = to_f(m_ct);
    e.cs  = m_cs;
    e.cl  = m_cl;
    sb.push_back(e);
  endfunction

  function automatic void model_reset();
    m_mode = M_UNL;
    m_t = -86400;
    m_pend = -86400;
    m_ct = -86400;
    m_sub = 0;
    m_cs = 0;
    m_hc = 0;
    m_reload = 0;
    m_cl = 0;
    m_mism = 0;
    m_bad = 0;
    m_cv = 0;
  endfunction

  function automatic void model_step();
    int yl, f, s, mi, h, d, hmax;
    int unsigned cps;
    bit ok, fok, late;
    cps  = bus.cycles_per_sec;
    hmax = int'(bus.holdover_max);
    yl   = bus.leap ? 366 : 365;
    s    = int'(bus.sec);
    mi   = int'(bus.min);
    h    = int'(bus.hr);
    d    = int'(bus.day);
    ok   = s <= 59 && mi <= 59 && h <= 23 && d >= 1 && d <= yl;
    fok  = bus.bcd_valid && ok;
    f    = to_s(d, h, mi, s);
    m_bad  = bus.bcd_valid && !ok;
    m_mism = 0;
    m_cv   = bus.trigger;
    if (bus.trigger) begin
      m_ct = m_t;
      m_cs = m_sub;
      m_cl = m_mode >= M_LCK;
    end
    if (m_mode == M_UNL) begin
      if (fok) begin
        m_pend = f;
        m_mode = M_WAIT;
      end
    end else if (m_mode == M_WAIT) begin
      if (bus.pps) begin
        m_t = nxt(m_pend);
        m_sub = 0;
        m_mode = M_LCK;
      end
      if (fok) m_pend = f;
    end else begin
      if (bus.pps) begin
        late = (m_mode == M_HOLD) && (m_sub < cps / 2);
        if (!late) begin
          m_t = nxt(m_reload ? m_pend : m_t);
          m_reload = 0;
        end
        m_sub = 0;
        m_hc = 0;
        m_mode = M_LCK;
      end else if (m_sub == cps - 1) begin
        m_t = nxt(m_t);
        m_sub = 0;
        m_hc = m_hc + 1;
        m_mode = M_HOLD;
        if (hmax != 0 && m_hc == hmax) begin
          m_mode = M_UNL;
          m_hc = 0;
        end
      end else begin
        m_sub = m_sub + 1;
      end
      if (fok && f != m_t) begin
        m_mism = 1;
        m_pend = f;
        m_reload = 1;
      end
      if (m_mode == M_UNL) m_reload = 0;
    end
    push_exp();
  endfunction

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h",
               nm, $time, act, exp);
    end
  endfunction

  function automatic void chk_zero(string nm);
    chk({nm, "_time"},
        {6'd0, bus.t_day, bus.t_hr, bus.t_min, bus.t_sec,
         bus.t_subsec}, 64'd0);
    chk({nm, "_status"},
        {58'd0, bus.locked, bus.holdover, bus.mismatch,
         bus.bad_frame, bus.cap_valid, bus.cap_locked}, 64'd0);
    chk({nm, "_cap"},
        {6'd0, bus.cap_day, bus.cap_hr, bus.cap_min, bus.cap_sec,
         bus.cap_subsec}, 64'd0);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("time",
            {6'd0, bus.t_day, bus.t_hr, bus.t_min, bus.t_sec,
             bus.t_subsec}, {6'd0, e.t, e.sub});
        chk("status", {62'd0, bus.locked, bus.holdover},
            {62'd0, e.st});
        chk("pulses",
            {61'd0, bus.mismatch, bus.bad_frame, bus.cap_valid},
            {61'd0, e.pl});
        chk("capture",
            {5'd0, bus.cap_day, bus.cap_hr, bus.cap_min,
             bus.cap_sec, bus.cap_subsec, bus.cap_locked},
            {5'd0, e.ct, e.cs, e.cl});
      end
    end
  end

  task automatic tick(input bit p = 0, input bit t = 0,
                      input bit v = 0, input int s = 0,
                      input int mi = 0, input int h = 0,
                      input int d = 0);
    bus.pps = p;
    bus.trigger = t;
    bus.bcd_valid = v;
    bus.sec = 6'(s);
    bus.min = 6'(mi);
    bus.hr = 5'(h);
    bus.day = 9'(d);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame(input int s, input int mi,
                       input int h, input int d);
    tick(0, 0, 1, s, mi, h, d);
  endtask

  task automatic pps_sec(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      idle(int'(bus.cycles_per_sec) - 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pps = 1'b0;
    bus.trigger = 1'b0;
    bus.bcd_valid = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    push_exp();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_seg(input int ncyc);
    int pc, per, cps;
    cps = int'(bus.cycles_per_sec);
    per = cps;
    pc = 0;
    for (int i = 0; i < ncyc; i++) begin
      bit p, t, v;
      int s, mi, h, d;
      logic [25:0] cur;
      p = 0;
      pc++;
      if (pc >= per) begin
        pc = 0;
        p = $urandom_range(0, 9) < 8;
        if ($urandom_range(0, 3) == 0)
          per = $urandom_range(2, 2 * cps);
        else
          per = cps;
      end
      t = $urandom_range(0, 9) == 0;
      v = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 1) == 0) begin
        cur = to_f(m_t);
        d = int'(cur[25:17]);
        h = int'(cur[16:12]);
        mi = int'(cur[11:6]);
        s = int'(cur[5:0]);
      end else begin
        s = $urandom_range(0, 61);
        mi = $urandom_range(0, 60);
        h = $urandom_range(0, 24);
        d = $urandom_range(0, 367);
      end
      tick(p, t, v, s, mi, h, d);
    end
  endtask

  initial begin
    bus.cycles_per_sec = 32'd1000;
    bus.holdover_max = 8'd3;
    bus.leap = 1'b0;
    bus.pps = 1'b0;
    bus.trigger = 1'b0;
    bus.bcd_valid = 1'b0;
    bus.sec = '0;
    bus.min = '0;
    bus.hr = '0;
    bus.day = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    frame(56, 34, 12, 100);
    idle(3);
    pps_sec(3);

    do_reset();
    frame(58, 59, 23, 365);
    idle(5);
    pps_sec(3);

    bus.leap = 1'b1;
    do_reset();
    frame(58, 59, 23, 365);
    idle(5);
    pps_sec(3);
    frame(58, 59, 23, 366);
    idle(5);
    pps_sec(3);

    bus.leap = 1'b0;
    do_reset();
    frame(56, 34, 12, 100);
    idle(3);
    pps_sec(1);
    idle(201);
    tick(1);
    idle(1699);
    tick(1);
    idle(3500);
    tick(1);
    idle(10);

    do_reset();
    frame(4, 0, 10, 1);
    idle(2);
    tick(1);
    idle(10);
    frame(9, 0, 10, 1);
    idle(988);
    tick(1);
    frame(60, 0, 10, 1);
    idle(998);
    tick(1, 1);
    tick(0, 1);
    tick(0, 1);
    idle(50);
    do_reset();
    tick(1);
    idle(5);
    tick(1, 0, 1, 3, 2, 1, 5);
    idle(5);
    tick(1, 0, 1, 4, 2, 1, 5);
    idle(20);

    for (int k = 0; k < 4; k++) begin
      bus.cycles_per_sec = 32'($urandom_range(4, 20));
      bus.holdover_max = 8'($urandom_range(0, 4));
      bus.leap = 1'($urandom_range(0, 1));
      do_reset();
      rand_seg(1500);
    end

    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irig_time_keeper.md
# irig_time_keeper

Free-running time-of-day keeper downstream of the IRIG BCD decoder. Takes each decoded frame (sec/min/hr/day with a valid strobe) and the decoder's per-second pps. Disciplines a local seconds/sub-second counter to that pps, flywheels through missing pps pulses (holdover) and latches a timestamp on an external trigger for the capture path.

## Interface
- No parameters; all configuration is run-time (matching the decoder's register-driven calibration inputs).
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- cycles_per_sec  in  32  nominal clk cycles per second (≥4); sampled continuously.
- holdover_max  in  8  maximum self-timed seconds before losing lock; 0 = unlimited.
- leap  in  1  1: day wraps after 366, 0: after 365.
- sec, min  in  6 each  decoded fields from decoder.
- hr  in  5  decoded hour.
- day  in  9  decoded day-of-year.
- bcd_valid  in  1  one-cycle strobe, decoded fields valid.
- pps  in  1  one-cycle strobe marking start of a second.
- trigger  in  1  one-cycle capture request.
- t_sec, t_min  out  6 each  running time.
- t_hr  out  5  running hour.
- t_day  out  9  running day.
- t_subsec  out  32  clk cycles since last second boundary.
- locked  out  1  high in LOCKED or HOLDOVER.
- holdover  out  1  high in HOLDOVER.
- mismatch  out  1  one-cycle pulse: decoded frame disagreed with running time.
- bad_frame  out  1  one-cycle pulse: out-of-range decoded fields, frame dropped.
- cap_sec, cap_min, cap_hr, cap_day, cap_subsec  out  6/6/5/9/32  captured timestamp.
- cap_locked  out  1  locked at capture time.
- cap_valid  out  1  one-cycle pulse, capture fields updated.

## Operation
- Frame range check on bcd_valid: sec≤59, min≤59, hr≤23, 1≤day≤(leap?366:365); fail → bad_frame pulse, frame ignored in every state.
- Accepted frame is stored in pending registers. Frame reports the second begun by the preceding pps. At the next pps, time loads pending+1 s.
- +1 s increment: sec 59→0 carries min; min 59→0 carries hr; hr 23→0 carries day; day 365 (leap=0) or 366 (leap=1) → 1.
- States:
  - UNLOCKED: subsec held; pps ignored. Accepted frame → WAIT_PPS.
  - WAIT_PPS: a new frame overwrites pending. On pps: t_* ← pending+1, subsec←0 → LOCKED.
  - LOCKED: subsec +1 per cycle. On pps: t_*+1 s (or pending+1 if a reload is flagged), subsec←0. Accepted frame is compared with t_* after this cycle's update; on any field differing: mismatch pulse, pending←frame, reload flag set (consumed at next pps). If subsec==cycles_per_sec−1 with no pps: next cycle t_*+1 s, subsec←0, holdover count←1 → HOLDOVER.
  - HOLDOVER: same self-timing. Each self-increment bumps the holdover count. If holdover_max≠0 and count reaches holdover_max at an increment → UNLOCKED. Fields retain their last values and reload is cleared.
  - pps in HOLDOVER: if subsec < cycles_per_sec>>1 it is a late edge of the current second (subsec←0, no increment); otherwise t_*+1 s, subsec←0. Either way → LOCKED with holdover count cleared. Frames in HOLDOVER are treated as in LOCKED.
- Capture: trigger samples the t_*, t_subsec and locked registers as they stand in the trigger cycle (pre-update on a coincident pps). Back-to-back triggers each capture.

## Timing
- Reset values: every output 0; state UNLOCKED; pending, reload and holdover count 0. Reset mid-operation aborts immediately with no pending carry-over.
- pps at cycle N → new t_* and t_subsec=0 visible at N+1; t_subsec=1 at N+2.
- bcd_valid at N → mismatch/bad_frame pulse at N+1.
- trigger at N → cap_* and cap_valid at N+1.
- Simultaneous bcd_valid and pps in WAIT_PPS: pps uses the old pending; the new frame becomes pending and the state goes to LOCKED.
- All arithmetic is unsigned. The subsec compare uses the full 32 bits, with no wrap below cycles_per_sec.

## Test plan
- Setup: cycles_per_sec=1000, leap=0, holdover_max=3. Frame 12:34:56 day 100, then pps → next cycle t=12:34:57 d100, subsec 0, locked=1.
- pps every 1000 cycles from 23:59:59 d365 → 00:00:00 d1. Repeat with leap=1 from d365 → d366, then → d1.
- Stop pps → t_* increments every 1000 cycles with holdover=1. After the 3rd self-increment, locked=0 and fields freeze. Resume with pps at subsec 200 → no increment, LOCKED.
- While LOCKED at 10:00:05, send frame 10:00:09 → mismatch pulse. Next pps → t=10:00:10.
- Frame sec=60 → bad_frame pulse, state unchanged. trigger coincident with pps at 10:00:10 subsec 999 → cap 10:00:10/999, cap_locked=1.
- Assert rst mid-LOCKED → all outputs 0 asynchronously. The first pps after reset is ignored until an accepted frame arrives.
